// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one word read at a time
// on the memory read port and buffers {pc, word} pairs in a small prefetch
// FIFO for the instruction handler. Branch redirects flush the FIFO and
// restart fetch at the target, discarding any read already in flight.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              mem_rd_addr,
    output logic                     mem_rd_addr_valid,
    input  logic [31:0]              mem_rd_data,
    input  logic                     mem_rd_ack,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ack,
    input  logic [31:0]              pc_branch_data,
    input  logic                     pc_branch_data_valid,
    output logic                     pc_branch_data_ack,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int           PW      = $clog2(DEPTH);
    localparam logic [PW:0]  DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic          redir;
    logic          push;
    logic          pop;
    logic [PW:0]   count_next;
    logic          space;
    logic [31:0]   target;
    logic [31:0]   pc_inc;

    // A redirect is taken only when not already acknowledging the previous one.
    assign redir  = pc_branch_data_valid && !pc_branch_data_ack;
    // Data acked in REQ is kept unless a redirect lands in the same cycle.
    assign push   = (state == REQ) && mem_rd_ack && !redir;
    assign pop    = instr_valid && instr_ack && !redir;
    assign target = pc_branch_data & ~32'h0000_0003;
    assign pc_inc = fetch_pc + 32'd4;

    // Occupancy after this cycle's push/pop/flush; gates issuing the next read.
    always_comb begin
        count_next = count;
        if (redir)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    assign space = (count_next < DEPTH_C);

    assign instr       = fifo_q[rd_ptr].word;
    assign instr_pc    = fifo_q[rd_ptr].pc;
    assign instr_valid = (count != '0);
    assign queue_count = count;

    // Fetch FSM: the request address is only ever changed once the
    // outstanding read has been acked, so a redirect mid-read goes via DROP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            fetch_pc           <= RESET_PC;
            mem_rd_addr        <= RESET_PC;
            mem_rd_addr_valid  <= 1'b0;
            pc_branch_data_ack <= 1'b0;
        end else begin
            pc_branch_data_ack <= redir;
            case (state)
                IDLE: begin
                    if (redir) begin
                        fetch_pc          <= target;
                        mem_rd_addr       <= target;
                        mem_rd_addr_valid <= 1'b1;
                        state             <= REQ;
                    end else if (space) begin
                        mem_rd_addr       <= fetch_pc;
                        mem_rd_addr_valid <= 1'b1;
                        state             <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rd_ack) begin
                        if (redir) begin
                            fetch_pc          <= target;
                            mem_rd_addr       <= target;
                            mem_rd_addr_valid <= 1'b1;
                        end else begin
                            fetch_pc <= pc_inc;
                            if (space) begin
                                mem_rd_addr       <= pc_inc;
                                mem_rd_addr_valid <= 1'b1;
                            end else begin
                                mem_rd_addr_valid <= 1'b0;
                                state             <= IDLE;
                            end
                        end
                    end else if (redir) begin
                        fetch_pc <= target;
                        state    <= DROP;
                    end
                end
                DROP: begin
                    if (redir)
                        fetch_pc <= target;
                    if (mem_rd_ack) begin
                        mem_rd_addr       <= redir ? target : fetch_pc;
                        mem_rd_addr_valid <= 1'b1;
                        state             <= REQ;
                    end
                end
                default: begin
                    mem_rd_addr_valid <= 1'b0;
                    state             <= IDLE;
                end
            endcase
        end
    end

    // Prefetch FIFO: a redirect flushes it and overrides any same-cycle pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                fifo_q[i] <= '0;
        end else begin
            count <= count_next;
            if (redir) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_q[wr_ptr] <= {fetch_pc, mem_rd_data};
                    wr_ptr         <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue. A second instance with a reset PC
// near the top of the address space covers fetch-PC wraparound.
module tb_instr_fetch_queue;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;

    logic [31:0] mem_rd_addr;
    logic        mem_rd_addr_valid;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rd_ack  = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ack   = 1'b0;
    logic [31:0] pc_branch_data       = '0;
    logic        pc_branch_data_valid = 1'b0;
    logic        pc_branch_data_ack;
    logic [2:0]  queue_count;

    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_data = '0;
    logic        w_ack  = 1'b0;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_instr_valid;
    logic        w_instr_ack = 1'b1;
    logic [31:0] w_br_data   = '0;
    logic        w_br_valid  = 1'b0;
    logic        w_br_ack;
    logic [2:0]  w_count;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          mem_auto = 1'b0;
    logic [127:0] got;
    logic [127:0] exp;

    instr_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
        .clk(clk), .reset(reset),
        .mem_rd_addr(mem_rd_addr), .mem_rd_addr_valid(mem_rd_addr_valid),
        .mem_rd_data(mem_rd_data), .mem_rd_ack(mem_rd_ack),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ack(instr_ack),
        .pc_branch_data(pc_branch_data), .pc_branch_data_valid(pc_branch_data_valid),
        .pc_branch_data_ack(pc_branch_data_ack), .queue_count(queue_count)
    );

    instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
        .clk(clk), .reset(reset),
        .mem_rd_addr(w_addr), .mem_rd_addr_valid(w_valid),
        .mem_rd_data(w_data), .mem_rd_ack(w_ack),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
        .instr_ack(w_instr_ack),
        .pc_branch_data(w_br_data), .pc_branch_data_valid(w_br_valid),
        .pc_branch_data_ack(w_br_ack), .queue_count(w_count)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is derived from its address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Advance one clock; zero-wait memory acks whatever request is showing.
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_auto) begin
            mem_rd_ack  = mem_rd_addr_valid;
            mem_rd_data = word_of(mem_rd_addr);
        end
        w_ack  = w_valid;
        w_data = word_of(w_addr);
    endtask

    task automatic do_reset();
        reset                = 1'b0;
        mem_auto             = 1'b0;
        mem_rd_ack           = 1'b0;
        instr_ack            = 1'b0;
        pc_branch_data_valid = 1'b0;
        w_ack                = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = {mem_rd_addr, 3'b0, mem_rd_addr_valid, 3'b0, instr_valid, 1'b0, queue_count, 3'b0, pc_branch_data_ack};
        exp = {32'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_ctrl: got %h expected %h", got, exp); end
        got = {instr, instr_pc};
        exp = '0;
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_head: got %h expected %h", got, exp); end
        got = {w_addr, 3'b0, w_valid};
        exp = {32'hFFFF_FFF8, 4'h0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_pc_param: got %h expected %h", got, exp); end
    endtask

    task automatic test_stream();
        do_reset();
        mem_auto  = 1'b1;
        instr_ack = 1'b1;
        step();
        got = {mem_rd_addr_valid, mem_rd_addr};
        exp = {1'b1, 32'h0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL stream_first_req: got %h expected %h", got, exp); end
        for (int k = 1; k <= 4; k++) begin
            step();
            got = {mem_rd_addr_valid, mem_rd_addr, instr_valid, instr_pc, instr, queue_count};
            exp = {1'b1, 32'(4*k), 1'b1, 32'(4*(k-1)), word_of(32'(4*(k-1))), 3'd1};
            n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL stream_k%0d: got %h expected %h", k, got, exp); end
        end
    endtask

    task automatic test_fill();
        do_reset();
        mem_auto  = 1'b1;
        instr_ack = 1'b0;
        repeat (4) step();
        got = {mem_rd_addr_valid, mem_rd_addr, queue_count};
        exp = {1'b1, 32'hC, 3'd3};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL fill_three: got %h expected %h", got, exp); end
        step();
        got = {mem_rd_addr_valid, queue_count, instr_valid, instr_pc, instr};
        exp = {1'b0, 3'd4, 1'b1, 32'h0, word_of(32'h0)};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL fill_full: got %h expected %h", got, exp); end
        repeat (2) step();
        got = {mem_rd_addr_valid, queue_count};
        exp = {1'b0, 3'd4};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL fill_no_fifth: got %h expected %h", got, exp); end
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        got = {mem_rd_addr_valid, mem_rd_addr, queue_count, instr_pc};
        exp = {1'b1, 32'h10, 3'd3, 32'h4};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL fill_pop_refetch: got %h expected %h", got, exp); end
        step();
        got = {mem_rd_addr_valid, queue_count, instr_pc};
        exp = {1'b0, 3'd4, 32'h4};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL fill_refull: got %h expected %h", got, exp); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        mem_auto  = 1'b1;
        instr_ack = 1'b0;
        repeat (3) step();
        mem_auto   = 1'b0;
        mem_rd_ack = 1'b0;
        got = {mem_rd_addr_valid, mem_rd_addr, queue_count};
        exp = {1'b1, 32'h8, 3'd2};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL drop_setup: got %h expected %h", got, exp); end
        pc_branch_data       = 32'h0000_0103;
        pc_branch_data_valid = 1'b1;
        step();
        got = {pc_branch_data_ack, mem_rd_addr_valid, mem_rd_addr, instr_valid, queue_count};
        exp = {1'b1, 1'b1, 32'h8, 1'b0, 3'd0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL drop_taken: got %h expected %h", got, exp); end
        step();
        pc_branch_data_valid = 1'b0;
        got = {pc_branch_data_ack, mem_rd_addr_valid, mem_rd_addr};
        exp = {1'b0, 1'b1, 32'h8};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL drop_ack_pulse: got %h expected %h", got, exp); end
        step();
        got = {pc_branch_data_ack, mem_rd_addr_valid, mem_rd_addr};
        exp = {1'b0, 1'b1, 32'h8};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL drop_addr_held: got %h expected %h", got, exp); end
        mem_rd_ack  = 1'b1;
        mem_rd_data = 32'hDEAD_BEEF;
        step();
        mem_rd_ack = 1'b0;
        got = {mem_rd_addr_valid, mem_rd_addr, instr_valid, queue_count};
        exp = {1'b1, 32'h100, 1'b0, 3'd0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL drop_restart: got %h expected %h", got, exp); end
        step();
        got = {pc_branch_data_ack, mem_rd_addr, queue_count};
        exp = {1'b0, 32'h100, 3'd0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL drop_settled: got %h expected %h", got, exp); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        mem_auto  = 1'b1;
        instr_ack = 1'b0;
        repeat (2) step();
        got = {mem_rd_addr, queue_count, instr_pc};
        exp = {32'h4, 3'd1, 32'h0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL coinc_setup: got %h expected %h", got, exp); end
        mem_auto             = 1'b0;
        mem_rd_ack           = 1'b1;
        mem_rd_data          = word_of(32'h4);
        instr_ack            = 1'b1;
        pc_branch_data       = 32'h0000_02FE;
        pc_branch_data_valid = 1'b1;
        step();
        pc_branch_data_valid = 1'b0;
        mem_rd_ack           = 1'b0;
        instr_ack            = 1'b0;
        got = {pc_branch_data_ack, queue_count, instr_valid, mem_rd_addr_valid, mem_rd_addr};
        exp = {1'b1, 3'd0, 1'b0, 1'b1, 32'h2FC};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL coinc_flush: got %h expected %h", got, exp); end
        step();
        got = {pc_branch_data_ack, mem_rd_addr, queue_count};
        exp = {1'b0, 32'h2FC, 3'd0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL coinc_hold: got %h expected %h", got, exp); end
        mem_rd_ack  = 1'b1;
        mem_rd_data = word_of(32'h2FC);
        step();
        mem_rd_ack = 1'b0;
        got = {instr_valid, instr_pc, instr, queue_count, mem_rd_addr};
        exp = {1'b1, 32'h2FC, word_of(32'h2FC), 3'd1, 32'h300};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL coinc_target_word: got %h expected %h", got, exp); end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        got = {w_valid, w_addr};
        exp = {1'b1, 32'hFFFF_FFF8};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL wrap_first: got %h expected %h", got, exp); end
        step();
        got = {w_addr, w_instr_pc};
        exp = {32'hFFFF_FFFC, 32'hFFFF_FFF8};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL wrap_fffc: got %h expected %h", got, exp); end
        step();
        got = {w_addr, w_instr_pc, w_instr};
        exp = {32'h0, 32'hFFFF_FFFC, word_of(32'hFFFF_FFFC)};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL wrap_zero: got %h expected %h", got, exp); end
        step();
        got = {w_addr, w_instr_pc, w_count};
        exp = {32'h4, 32'h0, 3'd1};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL wrap_after: got %h expected %h", got, exp); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_auto  = 1'b1;
        instr_ack = 1'b0;
        repeat (3) step();
        mem_auto   = 1'b0;
        mem_rd_ack = 1'b0;
        got = {mem_rd_addr_valid, mem_rd_addr, queue_count};
        exp = {1'b1, 32'h8, 3'd2};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rstmid_setup: got %h expected %h", got, exp); end
        #2;
        reset = 1'b0;
        #1;
        got = {mem_rd_addr_valid, instr_valid, queue_count, mem_rd_addr, pc_branch_data_ack};
        exp = {1'b0, 1'b0, 3'd0, 32'h0, 1'b0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rstmid_async: got %h expected %h", got, exp); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        got = {mem_rd_addr_valid, mem_rd_addr, queue_count};
        exp = {1'b1, 32'h0, 3'd0};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rstmid_restart: got %h expected %h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction fetch stage directly upstream of the instruction handler.
- Owns the fetch PC and issues word reads on the memory read port (mem_rd_addr/valid/data/ack).
- Buffers returned instruction words, each tagged with its PC, in a small prefetch FIFO for the handler to consume.
- Accepts branch/jump redirects from the ALU branch path: flushes the queue and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_rd_addr  output  32  fetch word address.
- mem_rd_addr_valid  output  1  read request; held with a stable address until mem_rd_ack.
- mem_rd_data  input  32  instruction word; valid in the mem_rd_ack cycle.
- mem_rd_ack  input  1  one-cycle completion pulse for the outstanding request.
- instr  output  32  head-of-queue instruction.
- instr_pc  output  32  PC of instr.
- instr_valid  output  1  queue not empty.
- instr_ack  input  1  consumer pops the head when instr_valid && instr_ack.
- pc_branch_data  input  32  redirect target.
- pc_branch_data_valid  input  1  redirect request.
- pc_branch_data_ack  output  1  one-cycle redirect acknowledge.
- queue_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - mem_rd_addr = RESET_PC, mem_rd_addr_valid = 0, fetch_pc = RESET_PC.
  - instr_valid = 0, queue_count = 0, pc_branch_data_ack = 0.
  - instr and instr_pc = 0. State = IDLE.
- All outputs are registered, or driven straight from FIFO head/count registers.
- States:
  - IDLE: no request outstanding. If reserve-space is available, go to REQ: assert valid, drive fetch_pc.
  - REQ: request outstanding. On mem_rd_ack, push {fetch_pc, mem_rd_data} and set fetch_pc += 4 (32-bit wrap, FFFF_FFFC -> 0). In that same cycle, if space remains after the push, stay in REQ with valid high and the address updated next cycle (back-to-back fetch). Otherwise go to IDLE with valid low.
  - DROP: request outstanding whose data must be discarded. Keep valid and the address stable. On mem_rd_ack, discard the data and go to REQ at the redirected fetch_pc.
- Space rule: issue or continue only if (count after this cycle's push/pop) < DEPTH. The queue therefore never overflows.
- Redirect on pc_branch_data_valid, sampled at a clock edge:
  - FIFO cleared next cycle (count = 0, instr_valid = 0). A pop in the same cycle is ignored.
  - fetch_pc = {pc_branch_data[31:2], 2'b00}.
  - pc_branch_data_ack pulses high for exactly one cycle, the cycle after sampling. A second valid while ack is high is ignored.
  - From IDLE: go to REQ at the target on the next cycle.
  - From REQ without ack that cycle: go to DROP. The memory address is never changed mid-request.
  - From REQ with ack that cycle: the acked data is discarded, not pushed; go to REQ at the target.
  - From DROP: target replaced by the newest value; stay in DROP.
- Pop: on instr_valid && instr_ack, the head advances. New head data is visible the next cycle.
- Simultaneous push and pop: count unchanged, both take effect.
- Latency:
  - Request to queue: 1 cycle from mem_rd_ack to instr_valid when the queue was empty.
  - First mem_rd_addr_valid: the first edge after reset deasserts.
- Asynchronous reset mid-request abandons the request. Memory is reset by the same signal.

Test Plan:
- Reset release, zero-wait memory (ack 1 cycle after valid), instr_ack tied 1 -> addresses 0,4,8,C issued back-to-back. instr/instr_pc stream pairs {word,0},{word,4},…; count never exceeds 1.
- instr_ack held 0, DEPTH=4 -> exactly 4 acked reads (0..C), then valid drops. count=4, no fifth request. Releasing instr_ack for one cycle -> one new read at 0x10.
- Redirect to 0x0000_0103 while REQ at 0x8 has no ack, memory acks 3 cycles later -> address 0x8 held until ack, data dropped. Next request at 0x100; pc_branch_data_ack single pulse; queue empty.
- Redirect coincident with mem_rd_ack and instr_ack -> acked word not queued, pop ignored, count=0. Next address = target.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- Assert reset low while REQ outstanding with 2 queued entries -> immediately valid=0, instr_valid=0, count=0. After release, fetch restarts at RESET_PC.
